// File: rtl/sipo_frame_pkg.sv
// sipo_frame_pkg: shared FSM state type, framing constants and counter-width helper
package sipo_frame_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} state_t;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/sipo_shift_en.sv
// sipo_shift_en: N-bit shift register with enable; MSB_FIRST selects shift-left vs shift-right entry
module sipo_shift_en #(
  parameter int N = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         din,
  output logic [N-1:0] q
);
  // shift one bit in per enable, first bit ends up at the far end of the word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (en) q <= MSB_FIRST ? {q[N-2:0], din} : {din, q[N-1:1]};
endmodule

// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: framed serial-to-parallel receiver with one-word output buffer; SIPO_PARITY_EN adds even parity
module sipo_frame_ctrl
  import sipo_frame_pkg::*;
#(
  parameter int N = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         bit_valid,
  input  logic         serial_in,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         frame_err,
  output logic         parity_err,
  output logic         overrun
);
  localparam int CW = clog2(N);
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [N-1:0] sr;
  logic shift_en, stop_evt, commit, load, par_bad;

  sipo_shift_en #(.N(N), .MSB_FIRST(MSB_FIRST)) u_sr (
    .clk(clk), .rst_n(rst_n), .en(shift_en), .din(serial_in), .q(sr)
  );

  // frame sequencing: every transition is gated by the bit strobe
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    shift_en = 1'b0;
    if (bit_valid)
      case (state)
        IDLE: if (serial_in == START_BIT) begin
          state_nxt = SHIFT;
          cnt_nxt = '0;
        end
        SHIFT: begin
          shift_en = 1'b1;
          cnt_nxt = cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            cnt_nxt = '0;
`ifdef SIPO_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
        PARITY: state_nxt = STOP;
        default: state_nxt = IDLE;
      endcase
  end

  // state and bit counter registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end

  assign busy = state != IDLE;
  assign stop_evt = bit_valid && state == STOP;
  assign commit = stop_evt && serial_in == STOP_BIT && !par_bad;
  assign load = commit && (!out_valid || out_ready);

`ifdef SIPO_PARITY_EN
  // remember a parity mismatch until the frame's stop bit, cleared while hunting for start
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) par_bad <= 1'b0;
    else if (bit_valid && state == IDLE) par_bad <= 1'b0;
    else if (bit_valid && state == PARITY) par_bad <= serial_in != ^sr;

  // parity error reported only when the framing itself was good
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) parity_err <= 1'b0;
    else parity_err <= stop_evt && serial_in == STOP_BIT && par_bad;
`else
  assign par_bad = 1'b0;
  assign parity_err = 1'b0;
`endif

  // holding buffer, handshake and single-cycle error pulses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_data <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      out_valid <= load || (out_valid && !out_ready);
      if (load) out_data <= sr;
      frame_err <= stop_evt && serial_in != STOP_BIT;
      overrun <= commit && out_valid && !out_ready;
    end
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb_sipo_frame_ctrl: scoreboard bench for sipo_frame_ctrl (MSB-first main instance plus LSB-first companion)
module tb_sipo_frame_ctrl;
  localparam int N = 8;
  logic clk = 1'b0, rst_n = 1'b0, bit_valid = 1'b0, serial_in = 1'b1, out_ready = 1'b1;
  logic [N-1:0] out_data, l_data;
  logic out_valid, busy, frame_err, parity_err, overrun;
  logic l_valid, l_busy, l_fe, l_pe, l_ov;
  int n_chk = 0, n_fail = 0, gap = 0;
  int e_fe = 0, e_pe = 0, e_ov = 0, m_fe = 0, m_pe = 0, m_ov = 0;
  logic [N-1:0] exp_q[$];
  logic hold_v = 1'b0;
  logic [N-1:0] hold_d = '0;

  always #5 clk = ~clk;

  sipo_frame_ctrl #(.N(N), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .serial_in(serial_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  sipo_frame_ctrl #(.N(N), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .serial_in(serial_in),
    .out_data(l_data), .out_valid(l_valid), .out_ready(1'b1), .busy(l_busy),
    .frame_err(l_fe), .parity_err(l_pe), .overrun(l_ov)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bit_tx(input logic b);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bit_valid = 1'b1;
    serial_in = b;
    @(negedge clk);
    bit_valid = 1'b0;
    serial_in = 1'b1;
  endtask

  task automatic send_frame(input logic [N-1:0] d, input logic stop, input logic bad,
                            input logic ov, input logic vexp);
    logic push;
    push = stop && !bad && !ov;
    if (push) exp_q.push_back(d);
    e_fe += int'(!stop);
    e_pe += int'(stop && bad);
    e_ov += int'(ov);
    bit_tx(1'b0);
    for (int i = N - 1; i >= 0; i--) bit_tx(d[i]);
`ifdef SIPO_PARITY_EN
    bit_tx((^d) ^ bad);
`endif
    bit_tx(stop);
    check("frame_err", frame_err, !stop);
    check("parity_err", parity_err, stop && bad);
    check("overrun", overrun, ov);
    check("valid_lat", out_valid, vexp);
    if (push) check("data_lat", out_data, d);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) m_fe++;
      if (parity_err) m_pe++;
      if (overrun) m_ov++;
      if (frame_err || parity_err || overrun)
        check("excl", int'(frame_err) + int'(parity_err) + int'(overrun), 1);
      if (hold_v && out_valid) check("stable", out_data, hold_d);
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb_empty", exp_q.size(), 1);
        else check("data", out_data, exp_q.pop_front());
      end
    end else hold_v = 1'b0;
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_data", out_data, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {frame_err, parity_err, overrun}, 0);
    rst_n = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("valid_fall", out_valid, 0);
    send_frame(8'hC0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("lsb_valid", l_valid, 1);
    check("lsb_data", l_data, 8'h03);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge clk) #1 out_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b1, 1'b0, 1'b1, 1'b1);
    check("held", out_data, 8'h11);
    repeat (3) @(negedge clk);
    check("held_valid", out_valid, 1);
    @(posedge clk) #1 out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("drained", out_valid, 0);
    gap = 2;
    bit_tx(1'b0);
    for (int i = 0; i < 4; i++) bit_tx(i[0]);
    check("busy_mid", busy, 1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
    gap = 0;
`ifdef SIPO_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
`endif
    repeat (4) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    check("fe_count", m_fe, e_fe);
    check("pe_count", m_pe, e_pe);
    check("ov_count", m_ov, e_ov);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
